// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared constants for the bit-serial adder/subtractor.
// FSM state encodings and operating-mode encodings.
package serial_add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// full_adder_cell: one-bit full adder built from two half adders.
// Ports: a, b, cin in; s = sum bit, cout = carry out.
import serial_add_sub_pkg::*;

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    // Both half-adder carries can never be high together.
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + A, B, Cin, Sub
//        operand bundle; out_valid/out_ready + Sum, Carry, Overflow result;
//        busy is high while running or holding a result.
import serial_add_sub_pkg::*;

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (s),
        .cout (c_next)
    );

    // Partial sum holds the WIDTH-1 bits already produced; the bit being
    // computed this cycle completes the word.
    generate
        if (WIDTH > 1) begin : g_part
            logic [WIDTH-2:0] part;

            always_ff @(posedge clk) begin
                if (rst)
                    part <= '0;
                else if (state == ST_RUN)
                    part <= sum_next[WIDTH-1:1];
            end

            assign sum_next = {s, part};
        end else begin : g_one
            assign sum_next = s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        // Subtract as A + ~B + !Cin.
                        b_sh  <= (Sub == MODE_SUB) ? ~B : B;
                        c     <= Cin ^ Sub;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        Sum      <= sum_next;
                        Carry    <= c_next;
                        // Carry into MSB differs from carry out.
                        Overflow <= c ^ c_next;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed bench for serial_add_sub.
// WIDTH=8 vector table plus corner sequences, WIDTH=1 exhaustive.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv8, ir8, ov8, or8, cin8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       c8, o8, busy8;

    logic       iv1, ir1, ov1, or1, cin1, sub1;
    logic [0:0] a1, b1, sum1;
    logic       c1, o1, busy1;

    int checks = 0;
    int errors = 0;

    serial_add_sub #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .A         (a8),
        .B         (b8),
        .Cin       (cin8),
        .Sub       (sub8),
        .out_valid (ov8),
        .out_ready (or8),
        .Sum       (sum8),
        .Carry     (c8),
        .Overflow  (o8),
        .busy      (busy8)
    );

    serial_add_sub #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
        .Sub       (sub1),
        .out_valid (ov1),
        .out_ready (or1),
        .Sum       (sum1),
        .Carry     (c1),
        .Overflow  (o1),
        .busy      (busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one bundle, then wait (bounded) for out_valid.
    task automatic run8(input vec_t v, output int lat);
        a8   = v.a;
        b8   = v.b;
        cin8 = v.cin;
        sub8 = v.sub;
        iv8  = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic deliver8();
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    initial begin
        int   lat;
        int   first_acc;
        int   second_acc;
        logic prev;
        logic seen;
        vec_t v;

        vecs[0] = '{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        {iv8, or8, cin8, sub8, a8, b8} = '0;
        {iv1, or1, cin1, sub1, a1, b1} = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst in_ready", 64'(ir8), 64'd1);
        chk("rst out_valid", 64'(ov8), 64'd0);
        chk("rst busy", 64'(busy8), 64'd0);
        chk("rst sum", 64'(sum8), 64'd0);
        chk("rst carry", 64'(c8), 64'd0);
        chk("rst ovf", 64'(o8), 64'd0);
        chk("rst w1 in_ready", 64'(ir1), 64'd1);

        for (int i = 0; i < 8; i++) begin
            chk("vec in_ready", 64'(ir8), 64'd1);
            run8(vecs[i], lat);
            chk("vec latency", 64'(lat), 64'd8);
            chk("vec sum", 64'(sum8), 64'(vecs[i].sum));
            chk("vec carry", 64'(c8), 64'(vecs[i].carry));
            chk("vec ovf", 64'(o8), 64'(vecs[i].ovf));
            deliver8();
            chk("vec valid drop", 64'(ov8), 64'd0);
        end

        // Backpressure: a second bundle waits while the result is held.
        run8(vecs[0], lat);
        chk("bp latency", 64'(lat), 64'd8);
        a8   = 8'h01;
        b8   = 8'h02;
        cin8 = 1'b0;
        sub8 = 1'b0;
        iv8  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp out_valid", 64'(ov8), 64'd1);
            chk("bp in_ready", 64'(ir8), 64'd0);
            chk("bp sum", 64'(sum8), 64'h81);
            chk("bp carry", 64'(c8), 64'd0);
            chk("bp ovf", 64'(o8), 64'd1);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("bp idle busy", 64'(busy8), 64'd0);
        chk("bp idle in_ready", 64'(ir8), 64'd1);
        tick();
        iv8 = 1'b0;
        chk("bp accepted", 64'(busy8), 64'd1);
        lat = 0;
        while (!ov8 && lat < 50) begin
            tick();
            lat++;
        end
        chk("bp2 latency", 64'(lat), 64'd8);
        chk("bp2 sum", 64'(sum8), 64'h03);
        deliver8();

        // Back-to-back issue period.
        a8         = 8'h01;
        b8         = 8'h01;
        iv8        = 1'b1;
        or8        = 1'b1;
        prev       = busy8;
        first_acc  = -1;
        second_acc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (!prev && busy8) begin
                if (first_acc < 0)
                    first_acc = cyc;
                else if (second_acc < 0)
                    second_acc = cyc;
            end
            prev = busy8;
        end
        iv8 = 1'b0;
        for (int k = 0; k < 30 && busy8; k++)
            tick();
        or8 = 1'b0;
        chk("issue period", 64'(second_acc - first_acc), 64'd10);
        chk("drain idle", 64'(busy8), 64'd0);

        // Reset during RUN cycle 3.
        a8   = 8'hAA;
        b8   = 8'h55;
        cin8 = 1'b0;
        sub8 = 1'b0;
        iv8  = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        chk("pre-abort busy", 64'(busy8), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 64'(ir8), 64'd1);
        chk("abort busy", 64'(busy8), 64'd0);
        chk("abort out_valid", 64'(ov8), 64'd0);
        chk("abort sum", 64'(sum8), 64'd0);
        chk("abort carry", 64'(c8), 64'd0);
        chk("abort ovf", 64'(o8), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ov8)
                seen = 1'b1;
        end
        chk("abort no result", 64'(seen), 64'd0);
        v = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        run8(v, lat);
        chk("fresh latency", 64'(lat), 64'd8);
        chk("fresh sum", 64'(sum8), 64'hFF);
        chk("fresh carry", 64'(c8), 64'd0);
        chk("fresh ovf", 64'(o8), 64'd0);
        deliver8();

        // WIDTH=1 exhaustive against an integer reference.
        for (int i = 0; i < 16; i++) begin
            int ua, ub, uc, sa, sb, t, sr;
            logic es, ec, eo;
            logic [3:0] bits;
            bits = 4'(i);
            ua = int'(bits[0]);
            ub = int'(bits[1]);
            uc = int'(bits[2]);
            sa = -ua;
            sb = -ub;
            if (!bits[3]) begin
                t  = ua + ub + uc;
                es = t[0];
                ec = (t >= 2);
                sr = sa + sb + uc;
            end else begin
                t  = ua - ub - uc;
                es = t[0];
                ec = (ua >= ub + uc);
                sr = sa - sb - uc;
            end
            eo = (sr < -1) || (sr > 0);

            chk("w1 in_ready", 64'(ir1), 64'd1);
            a1   = bits[0];
            b1   = bits[1];
            cin1 = bits[2];
            sub1 = bits[3];
            iv1  = 1'b1;
            tick();
            iv1 = 1'b0;
            lat = 0;
            while (!ov1 && lat < 20) begin
                tick();
                lat++;
            end
            chk("w1 latency", 64'(lat), 64'd1);
            chk("w1 sum", 64'(sum1), 64'(es));
            chk("w1 carry", 64'(c1), 64'(ec));
            chk("w1 ovf", 64'(o1), 64'(eo));
            or1 = 1'b1;
            tick();
            or1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the single-bit combinational adder cell.
- Accepts two WIDTH-bit operands, a carry-in and a mode bit through a valid/ready handshake.
- Computes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Returns sum, carry/no-borrow and signed overflow through a valid/ready handshake. Intended for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, derived = (WIDTH>1) ? $clog2(WIDTH) : 1, bit-counter width; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (add) / borrow-in (sub).
- Sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  result, registered.
- Carry  out  1  carry-out; in subtract mode 1 = no borrow.
- Overflow  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high (rst sampled on rising clk). Reset forces state IDLE and clears all registers: in_ready=1, out_valid=0, Sum=0, Carry=0, Overflow=0, busy=0, counter=0.
- Reset asserted mid-operation aborts the operation. No result is produced, and the next cycle is IDLE.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a_sh=A, b_sh=Sub ? ~B : B, c=Cin^Sub, cnt=0, then go to RUN.
  - Inputs are sampled only at this edge; later changes on A/B/Cin/Sub are ignored.
- RUN:
  - in_ready=0.
  - Each edge computes s=a_sh[0]^b_sh[0]^c and c_next=maj(a_sh[0],b_sh[0],c).
  - sum_sh shifts right with s entering the MSB. a_sh and b_sh shift right. c<=c_next; cnt++.
  - At the edge where cnt==WIDTH-1: Carry<=c_next, Overflow<=c^c_next (carry into MSB xor carry out), Sum<=final shifted value, then go to DONE.
- DONE:
  - out_valid=1. Sum/Carry/Overflow are held stable while out_ready=0.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no overlap of accept and deliver.
- Latency and throughput:
  - out_valid rises exactly WIDTH cycles after the accepting edge.
  - Minimum issue period is WIDTH+2 cycles (accept, WIDTH RUN, DONE).
- Outputs outside DONE: Sum/Carry/Overflow retain the last delivered result (0 after reset). Consumers must qualify them with out_valid.
- Arithmetic:
  - Add: {Carry,Sum} = A + B + Cin.
  - Subtract: Sum = A - B - Cin mod 2^WIDTH; Carry = 1 iff A >= B + Cin (unsigned).
  - Overflow is per two's-complement rules in both modes.
- WIDTH=1: RUN lasts one cycle, cnt is a constant 0, and overflow = c_in ^ c_out of the single bit.
- Simultaneous in_valid in DONE or RUN: not accepted. The producer holds until in_ready.

Decomposition:
- Shared package/header holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Mode localparams: MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, full_adder_cell:
  - Ports a, b, cin, s, cout.
  - Built from two instances of the existing half_adder block plus an OR for carry.
  - Instantiated once as the serial datapath bit slice.
- FSM, counter and shift registers live in serial_add_sub.

Test Plan:
- WIDTH=8 add, A=0x3C, B=0x45, Cin=0 -> Sum=0x81, Carry=0, Overflow=1; out_valid exactly 8 cycles after accept edge.
- WIDTH=8 add, A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1, Overflow=0. Repeat with Cin=1 -> Sum=0x01, Carry=1.
- WIDTH=8 sub:
  - 0x10-0x20, Cin=0 -> Sum=0xF0, Carry=0, Overflow=0.
  - 0x80-0x01 -> Sum=0x7F, Carry=1, Overflow=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout, next in_valid bundle accepted only after out_ready handshake.
  - Back-to-back issue period measured = WIDTH+2.
- Reset mid-RUN: assert rst at RUN cycle 3 of A=0xAA+B=0x55 -> next cycle IDLE, out_valid never asserts, all outputs 0. A fresh op then completes correctly.
- WIDTH=1 instance: exhaustive 16 combinations of A, B, Cin, Sub against a reference model -> all Sum/Carry/Overflow match, latency 1.
